// File: rtl/edge_event_arbiter.sv
// Per-channel level-transition trackers feeding a round-robin arbiter that
// drains pending events one at a time through a single valid/ready port.
module edge_event_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             r,
  input  logic [N-1:0]     in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDW-1:0]   ev_id,
  output logic             ev_level,
  output logic [N-1:0]     pend,
  output logic [N-1:0]     ovf,
  input  logic             ovf_clr,
  output logic [2*N-1:0]   trk_state
);

  // Handshake: an event transfers on any rising edge where ev_valid and
  // ev_ready are both 1; ev_id/ev_level hold while ev_valid=1 and ev_ready=0.

  typedef enum logic [1:0] {
    TRK_INIT = 2'd0,
    TRK_LOW  = 2'd1,
    TRK_HIGH = 2'd2
  } trk_t;

  trk_t             r_trk     [N];
  trk_t             w_trk_nxt [N];
  logic [N-1:0]     w_ev;

  logic [N-1:0]     r_pend;
  logic [N-1:0]     r_lvl;
  logic [N-1:0]     r_ovf;
  logic             r_ev_valid;
  logic [IDW-1:0]   r_ev_id;
  logic             r_ev_level;
  logic [IDW-1:0]   r_ptr;

  logic             w_free;
  logic             w_gnt_any;
  logic [IDW-1:0]   w_gnt_id;
  logic             w_grant;
  logic [N-1:0]     w_gnt_oh;

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (r) r_trk[i] <= TRK_INIT;
      else   r_trk[i] <= w_trk_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_trk_nxt[i] = r_trk[i];
      case (r_trk[i])
        TRK_INIT: w_trk_nxt[i] = in[i] ? TRK_HIGH : TRK_LOW;
        TRK_LOW:  if (in[i])  w_trk_nxt[i] = TRK_HIGH;
        TRK_HIGH: if (!in[i]) w_trk_nxt[i] = TRK_LOW;
        default:  w_trk_nxt[i] = TRK_INIT;
      endcase
    end
  end

  // The baseline sample (INIT) never raises an event.
  always_comb begin
    w_ev = '0;
    for (int i = 0; i < N; i++) begin
      w_ev[i] = ((r_trk[i] == TRK_LOW)  &&  in[i]) ||
                ((r_trk[i] == TRK_HIGH) && !in[i]);
    end
  end

  always_comb begin
    trk_state = '0;
    for (int i = 0; i < N; i++) begin
      trk_state[2*i +: 2] = r_trk[i];
    end
  end

  // Walk from the farthest offset down so the nearest set bit after ptr wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int k = N; k >= 1; k--) begin
      if (r_pend[(int'(r_ptr) + k) % N]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = IDW'((int'(r_ptr) + k) % N);
      end
    end
  end

  assign w_free   = !r_ev_valid || ev_ready;
  assign w_grant  = w_free && w_gnt_any;
  assign w_gnt_oh = w_grant ? ({{(N-1){1'b0}}, 1'b1} << w_gnt_id) : '0;

  // A new event on the channel being granted re-arms pend without overflow.
  always_ff @(posedge clk) begin
    if (r) begin
      r_pend     <= '0;
      r_lvl      <= '0;
      r_ovf      <= '0;
      r_ev_valid <= 1'b0;
      r_ev_id    <= '0;
      r_ev_level <= 1'b0;
      r_ptr      <= IDW'(N - 1);
    end else begin
      r_pend <= w_ev | (r_pend & ~w_gnt_oh);
      r_lvl  <= (r_lvl & ~w_ev) | (in & w_ev);
      r_ovf  <= (ovf_clr ? '0 : r_ovf) | (w_ev & r_pend & ~w_gnt_oh);
      if (w_free) begin
        r_ev_valid <= w_gnt_any;
        if (w_gnt_any) begin
          r_ev_id    <= w_gnt_id;
          r_ev_level <= r_lvl[w_gnt_id];
          r_ptr      <= w_gnt_id;
        end
      end
    end
  end

  assign ev_valid = r_ev_valid;
  assign ev_id    = r_ev_id;
  assign ev_level = r_ev_level;
  assign pend     = r_pend;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios with literal expectations
// plus a per-cycle comparison against a behavioural event/arbitration model.
module tb_edge_event_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           r;
  logic [N-1:0]   in;
  logic           ev_valid;
  logic           ev_ready;
  logic [IDW-1:0] ev_id;
  logic           ev_level;
  logic [N-1:0]   pend;
  logic [N-1:0]   ovf;
  logic           ovf_clr;
  logic [2*N-1:0] trk_state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk(clk), .r(r), .in(in), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_id(ev_id), .ev_level(ev_level), .pend(pend), .ovf(ovf),
    .ovf_clr(ovf_clr), .trk_state(trk_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: an event is any difference from the previous sample
  // once a baseline exists; pending events sit in per-channel slots.
  bit             m_base;
  logic [N-1:0]   m_prev, m_pend, m_lvl, m_ovf, m_ev;
  logic           m_valid, m_level;
  int             m_id, m_ptr, m_g;
  logic [2*N-1:0] m_trk;

  always @(posedge clk) begin
    if (r) begin
      m_base = 0; m_prev = '0; m_pend = '0; m_lvl = '0; m_ovf = '0;
      m_valid = 0; m_id = 0; m_level = 0; m_ptr = N - 1;
    end else begin
      m_ev = m_base ? (in ^ m_prev) : '0;
      if (!m_valid || ev_ready) begin
        m_g = -1;
        for (int k = 1; k <= N; k++)
          if (m_g < 0 && m_pend[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        if (m_g >= 0) begin
          m_valid = 1; m_id = m_g; m_level = m_lvl[m_g]; m_ptr = m_g;
          m_pend[m_g] = 1'b0;
        end else begin
          m_valid = 0;
        end
      end
      m_ovf  = (ovf_clr ? '0 : m_ovf) | (m_ev & m_pend);
      m_pend = m_pend | m_ev;
      for (int i = 0; i < N; i++) if (m_ev[i]) m_lvl[i] = in[i];
      m_prev = in;
      m_base = 1;
    end
    for (int i = 0; i < N; i++)
      m_trk[2*i +: 2] = !m_base ? 2'd0 : (m_prev[i] ? 2'd2 : 2'd1);
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (ev_valid !== m_valid || pend !== m_pend || ovf !== m_ovf ||
          trk_state !== m_trk ||
          (m_valid && (int'(ev_id) != m_id || ev_level !== m_level))) begin
        errors++;
        $display("FAIL model_cmp t=%0t valid %b exp %b id %0d exp %0d lvl %b exp %b pend %b exp %b ovf %b exp %b trk %b exp %b",
                 $time, ev_valid, m_valid, ev_id, m_id, ev_level, m_level,
                 pend, m_pend, ovf, m_ovf, trk_state, m_trk);
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    r = 1'b1; in = '0; ev_ready = 1'b1; ovf_clr = 1'b0;
    cyc();
    chk_en = 1;
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_id", 32'(ev_id), 0);
    chk("rst_level", 32'(ev_level), 0);
    r = 1'b0;

    // single rising edge on channel 2
    repeat (3) cyc();
    in = 4'b0100;
    cyc();
    chk("t1_pend", 32'(pend), 32'h4);
    chk("t1_valid_early", 32'(ev_valid), 0);
    cyc();
    chk("t1_valid", 32'(ev_valid), 1);
    chk("t1_id", 32'(ev_id), 2);
    chk("t1_level", 32'(ev_level), 1);
    chk("t1_pend_clr", 32'(pend), 0);
    cyc();
    chk("t1_drained", 32'(ev_valid), 0);

    // baseline of all-ones raises nothing
    r = 1'b1; in = 4'b1111;
    cyc();
    r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t2_no_event", 32'({ev_valid, pend}), 0);
    end

    // all four fall at once; stall, then drain in ID order
    ev_ready = 1'b0; in = 4'b0000;
    cyc();
    chk("t3_pend_all", 32'(pend), 32'hF);
    cyc();
    chk("t3_first_id", 32'(ev_id), 0);
    chk("t3_first_valid", 32'(ev_valid), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_hold", 32'({ev_valid, ev_id, ev_level}), 32'({1'b1, 2'd0, 1'b0}));
    end
    ev_ready = 1'b1;
    for (int i = 1; i < N; i++) begin
      cyc();
      chk("t3_order", 32'({ev_valid, ev_id, ev_level}), 32'({1'b1, 2'(i), 1'b0}));
    end
    cyc();
    chk("t3_done", 32'(ev_valid), 0);

    // overflow on channel 1 while channel 3 occupies the output
    ev_ready = 1'b0; in = 4'b1000;
    cyc();
    cyc();
    chk("t4_occupy", 32'({ev_valid, ev_id, ev_level}), 32'({1'b1, 2'd3, 1'b1}));
    in = 4'b1010;
    cyc();
    chk("t4_pend1", 32'(pend), 32'h2);
    in = 4'b1000;
    cyc();
    chk("t4_ovf", 32'(ovf), 32'h2);
    ev_ready = 1'b1;
    cyc();
    chk("t4_ch1_event", 32'({ev_valid, ev_id, ev_level}), 32'({1'b1, 2'd1, 1'b0}));
    cyc();
    chk("t4_ovf_sticky", 32'(ovf), 32'h2);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(ovf), 0);

    // reset while presenting with pending and overflow state
    ev_ready = 1'b0; in = 4'b1001;
    cyc();
    in = 4'b1011;
    cyc();
    in = 4'b1001;
    cyc();
    chk("t5_pre", 32'({ev_valid, pend, ovf}), 32'({1'b1, 4'b0010, 4'b0010}));
    r = 1'b1;
    cyc();
    r = 1'b0; ev_ready = 1'b1;
    chk("t5_rst", 32'({ev_valid, pend, ovf, ev_id}), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t5_quiet", 32'(ev_valid), 0);
    end
    in = 4'b1000;
    cyc();
    chk("t5_pend", 32'(pend), 32'h1);
    cyc();
    chk("t5_event", 32'({ev_valid, ev_id, ev_level}), 32'({1'b1, 2'd0, 1'b0}));

    // same channel granted and re-triggered in one cycle
    in = 4'b1100;
    cyc();
    in = 4'b1000;
    cyc();
    chk("t6_regrant", 32'({ev_valid, ev_id, ev_level, pend, ovf}),
        32'({1'b1, 2'd2, 1'b1, 4'b0100, 4'b0000}));
    cyc();
    chk("t6_second", 32'({ev_valid, ev_id, ev_level, pend}), 32'({1'b1, 2'd2, 1'b0, 4'b0000}));

    // mixed traffic checked by the model only
    for (int i = 0; i < 300; i++) begin
      in       = 4'($urandom_range(0, 15));
      ev_ready = 1'($urandom_range(0, 1));
      ovf_clr  = ($urandom_range(0, 9) == 0);
      cyc();
    end
    ovf_clr = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel transition detector and round-robin event scheduler. Each of N single-bit inputs gets its own transition tracker. The tracker takes a baseline on the first sample after reset and flags every later level change. Pending events from all channels share one valid/ready output port, which a downstream consumer drains one event at a time, tagged with channel ID and new level.

## Interface
- N, 4, number of input channels (2..8)
- IDW, 2, width of channel ID; N <= 2^IDW required

- clk  input  1  rising-edge clock
- r  input  1  synchronous active-high reset
- in  input  N  asynchronous-free level inputs, one per channel, sampled on clk
- ev_valid  output  1  event presented on output port
- ev_ready  input  1  consumer accepts event when high with ev_valid
- ev_id  output  IDW  channel index of presented event
- ev_level  output  1  new level of that channel (1 = rose, 0 = fell)
- pend  output  N  per-channel pending (not yet issued) event flags
- ovf  output  N  sticky per-channel overflow flags
- ovf_clr  input  1  clears all ovf bits

## Operation
- Per-channel tracker states: INIT (no baseline), LOW, HIGH.
  - INIT: on the next sample, go to LOW or HIGH per in[i]. No event.
  - LOW with in[i]=1: go to HIGH and raise an event with level 1.
  - HIGH with in[i]=0: go to LOW and raise an event with level 0.
  - Otherwise the tracker holds state and raises no event.
- On an event, pend[i] is set and the channel's stored level lvl[i] is overwritten with the new level.
- Overflow: an event on channel i while pend[i]=1, with i not granted in the same cycle, sets ovf[i]=1. lvl[i] takes the latest level; the older event is lost.
- The output stage is free when ev_valid=0 or (ev_valid & ev_ready).
- Grant: when the output stage is free and any registered pend bit is set, the arbiter grants channel g.
  - g is the first set pend bit searching ptr+1, ptr+2, … modulo N.
  - ev_id and ev_level load from g and lvl[g]. ev_valid is set, pend[g] is cleared, and ptr updates to g.
- If no pend bit is set while the output stage is free, ev_valid is 0 next cycle.
- While ev_valid=1 and ev_ready=0, ev_id and ev_level hold stable.
- Same channel granted and raising a new event in one cycle: pend[g] stays 1, lvl[g] updates, no overflow.
- ovf_clr clears all ovf bits. If ovf_clr and an overflow on channel i occur in the same cycle, set wins for channel i.

## Timing
- All state updates on the rising edge of clk. There is no combinational path from in to any output.
- Reset (r=1 at an edge) values:
  - every tracker in INIT
  - pend=0, lvl=0, ovf=0
  - ev_valid=0, ev_id=0, ev_level=0
  - ptr=N-1, so channel 0 has first priority
- r has priority over every other input. A reset asserted mid-operation discards all pending and presented events immediately.
- First valid sample after reset only establishes the baseline. The earliest event is a change at the second sample after reset.
- Latency: a change sampled at edge E gives pend[i]=1 after E and ev_valid=1 after E+1, if the output stage is free at E+1.
- Throughput: one event per cycle while ev_ready is held high and events are pending.
- A handshake completes on an edge where ev_valid & ev_ready = 1. A new grant may present on that same edge, giving back-to-back valid.
- ev_ready is ignored while ev_valid=0.
- Fairness: with all channels continuously pending and ev_ready=1, grants cycle 0,1,…,N-1,0.

## Test plan
- Reset, hold in=4'b0000 for 3 cycles, then toggle in[2] to 1.
  - Expected: pend=4'b0100 one cycle later; ev_valid=1, ev_id=2, ev_level=1 the cycle after; pend=0 after acceptance.
- Release reset with in=4'b1111, then hold in=4'b1111 for 10 cycles.
  - Expected: no ev_valid, since the baseline does not produce events.
- Set ev_ready=0 and change all four inputs in one cycle, then raise ev_ready.
  - Expected: events issue in ID order 0,1,2,3 on consecutive accepts, ev_valid high throughout, each ev_level matching its input.
- Hold ev_ready=0 while channel 1 goes 0→1→0 on successive cycles and a prior event occupies the output.
  - Expected: ovf[1]=1 and the eventual channel-1 event has ev_level=0.
  - Then pulse ovf_clr: ovf=0.
- Assert r while ev_valid=1 and pend≠0.
  - Expected: next cycle ev_valid=0, pend=0, ovf=0, ev_id=0.
  - No event follows until a post-baseline change occurs.
- Stall with ev_ready=0 for 5 cycles while events are presented.
  - Expected: ev_id and ev_level stay constant across the stall.
